dram_axi_write_master: RTL
==========================

# dram_axi_write_master

Single-outstanding AXI4 write master that consumes the buffered pixel stream's DRAM write requests (address, length, 512-bit data) in the m_axi_aclk domain and issues them as single-beat INCR writes to the PS DDR port. It sits directly downstream of the Camera Link buffer/gearbox stage. It drives that stage's `dram_write_busy` back-pressure. It also keeps saturating status counters for software debug.

## Interface
Parameters:
- DRAM_ADDR_WIDTH, 48, byte address width of requests and AXI AW channel
- DRAM_DATA_WIDTH, 512, data width of requests and AXI W channel; must be a power of two ≥ 64
- CNT_WIDTH, 32, width of every status counter

Ports (reset reset, synchronous, active-high; clock m_axi_aclk):
- m_axi_aclk  in  1  clock for all logic
- reset  in  1  synchronous, active-high
- dram_write_en  in  1  one-cycle request strobe; also the upstream FIFO read enable
- dram_write_addr  in  DRAM_ADDR_WIDTH  byte address, valid with dram_write_en
- dram_write_len  in  8  AXI beats-1, valid with dram_write_en
- dram_write_data  in  DRAM_DATA_WIDTH  FIFO dout, valid the cycle after dram_write_en
- dram_write_busy  out  1  high while a request is in flight
- m_axi_awaddr  out  DRAM_ADDR_WIDTH; m_axi_awlen out 8; m_axi_awsize out 3; m_axi_awburst out 2; m_axi_awcache out 4; m_axi_awprot out 3; m_axi_awvalid out 1; m_axi_awready in 1
- m_axi_wdata  out  DRAM_DATA_WIDTH; m_axi_wstrb out DRAM_DATA_WIDTH/8; m_axi_wlast out 1; m_axi_wvalid out 1; m_axi_wready in 1
- m_axi_bresp  in  2; m_axi_bvalid in 1; m_axi_bready out 1
- write_done_count  out  CNT_WIDTH  B responses with OKAY/EXOKAY
- write_error_count  out  CNT_WIDTH  B responses with SLVERR/DECERR
- drop_count  out  CNT_WIDTH  requests received while busy
- len_error  out  1  sticky: a request had dram_write_len ≠ 0
- align_error  out  1  sticky: a request address was not DRAM_DATA_WIDTH/8-byte aligned

## Operation
- FSM states: IDLE, CAPTURE, SEND, RESP.
- IDLE: on dram_write_en, latch the address with its low log2(DRAM_DATA_WIDTH/8) bits forced to 0 and go to CAPTURE.
  - If the address was misaligned, set align_error.
  - If len ≠ 0, set len_error. The write is still issued as one beat with awlen=0; multi-beat bursts are not supported.
- CAPTURE: latch dram_write_data, assert awvalid and wvalid, go to SEND.
- SEND: awvalid and wvalid are tracked independently. Each deasserts on the cycle after its own handshake.
  - When both handshakes are done (either order, or the same cycle), go to RESP.
  - bready is high in SEND and in RESP.
- RESP: on bvalid&&bready, go to IDLE. Increment write_done_count if bresp[1]=0, otherwise write_error_count.
- dram_write_busy = (state ≠ IDLE), registered.
- dram_write_en outside IDLE: the request is ignored and drop_count increments. The data word for that request is lost.
- Constants: awsize = log2(DRAM_DATA_WIDTH/8) (6 for 512), awburst = 2'b01, awcache = 4'b0011, awprot = 3'b000, wstrb = all ones, wlast = 1 whenever wvalid.
- awaddr and wdata hold stable while their valid is high (AXI rule).
- Counters saturate at all ones; no wrap.
- Reset values: all valids 0, bready 0, busy 0, awaddr 0, wdata 0, counters 0, sticky flags 0, state IDLE.
- Reset mid-transaction drops valids immediately and abandons the outstanding write. The interconnect must be reset together with this block.

## Timing
- Request strobe in cycle T (IDLE):
  - busy = 1 in cycle T+1 (state CAPTURE).
  - awvalid = wvalid = 1 in cycle T+2.
- Zero-wait slave (awready = wready = 1, bvalid in the cycle after the handshakes):
  - handshakes in T+2;
  - RESP in T+3 with the B handshake in T+3;
  - IDLE and busy = 0 in T+4.
- Minimum spacing between accepted requests is therefore 4 cycles. Upstream's 16-cycle wait always exceeds this.
- Counters and flags update on the edge that ends the qualifying cycle and are visible the next cycle.
- Because busy lags dram_write_en by one cycle, an upstream that ignores busy for one cycle can cause a drop. The drop is counted, never silently lost.

## Test plan
- Single write, addr 0x4_0000_0000, data pattern 0xA5.., zero-wait slave:
  - awvalid/wvalid in T+2 with awaddr 0x4_0000_0000, awlen 0, awsize 6, wlast 1, wstrb all ones;
  - busy high T+1..T+3;
  - write_done_count = 1.
- AW stalled 5 cycles, W accepted immediately:
  - wvalid drops after 1 cycle, awvalid held 5 cycles with stable awaddr;
  - RESP is entered only after the AW handshake.
- bresp = 2'b10 on the second of three writes → write_error_count = 1, write_done_count = 2.
- Request addr 0x4_0000_0023 with len 3:
  - awaddr 0x4_0000_0000, awlen 0;
  - align_error = 1 and len_error = 1, both sticky across a following clean write.
- dram_write_en pulsed at T and T+1: one write issued, drop_count = 1.
- reset asserted while in SEND with awvalid high: all valids and busy are 0 the next cycle. A new request afterward completes normally.

Source files
------------

// File: rtl/dram_axi_write_master.sv
// Single-outstanding AXI4 write master: one request becomes one single-beat INCR write.
// Keeps saturating done/error/drop counters and sticky request-format error flags.
module dram_axi_write_master #(
    parameter int unsigned DRAM_ADDR_WIDTH = 48,
    parameter int unsigned DRAM_DATA_WIDTH = 512,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                         m_axi_aclk,
    input  logic                         reset,

    input  logic                         dram_write_en,
    input  logic [DRAM_ADDR_WIDTH-1:0]   dram_write_addr,
    input  logic [7:0]                   dram_write_len,
    input  logic [DRAM_DATA_WIDTH-1:0]   dram_write_data,
    output logic                         dram_write_busy,

    output logic [DRAM_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                   m_axi_awlen,
    output logic [2:0]                   m_axi_awsize,
    output logic [1:0]                   m_axi_awburst,
    output logic [3:0]                   m_axi_awcache,
    output logic [2:0]                   m_axi_awprot,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,

    output logic [DRAM_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DRAM_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                         m_axi_wlast,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,

    input  logic [1:0]                   m_axi_bresp,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,

    output logic [CNT_WIDTH-1:0]         write_done_count,
    output logic [CNT_WIDTH-1:0]         write_error_count,
    output logic [CNT_WIDTH-1:0]         drop_count,
    output logic                         len_error,
    output logic                         align_error
);

    localparam int unsigned ADDR_LSB = $clog2(DRAM_DATA_WIDTH / 8);
    localparam logic [DRAM_ADDR_WIDTH-1:0] LSB_MASK =
        DRAM_ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StSend,
        StResp
    } state_e;

    state_e                       r_state;
    logic                         r_busy;
    logic                         r_awvalid;
    logic                         r_wvalid;
    logic [DRAM_ADDR_WIDTH-1:0]   r_awaddr;
    logic [DRAM_DATA_WIDTH-1:0]   r_wdata;
    logic [CNT_WIDTH-1:0]         r_done_cnt;
    logic [CNT_WIDTH-1:0]         r_err_cnt;
    logic [CNT_WIDTH-1:0]         r_drop_cnt;
    logic                         r_len_error;
    logic                         r_align_error;

    state_e                       w_state_d;
    logic                         w_awvalid_d;
    logic                         w_wvalid_d;
    logic                         w_aw_done;
    logic                         w_w_done;
    logic                         w_accept;
    logic                         w_drop;
    logic                         w_b_hs;
    logic                         w_bresp_ok;

    assign w_accept   = (r_state == StIdle) && dram_write_en;
    assign w_drop     = (r_state != StIdle) && dram_write_en;
    // A channel counts as done once its handshake has happened or is happening now.
    assign w_aw_done  = !r_awvalid || m_axi_awready;
    assign w_w_done   = !r_wvalid || m_axi_wready;
    assign w_bresp_ok = (m_axi_bresp == 2'b00) || (m_axi_bresp == 2'b01);

    always_comb begin
        w_state_d   = r_state;
        w_awvalid_d = r_awvalid;
        w_wvalid_d  = r_wvalid;
        w_b_hs      = 1'b0;
        case (r_state)
            StIdle: begin
                if (dram_write_en) begin
                    w_state_d = StCapture;
                end
            end
            StCapture: begin
                w_awvalid_d = 1'b1;
                w_wvalid_d  = 1'b1;
                w_state_d   = StSend;
            end
            StSend: begin
                if (m_axi_awready) begin
                    w_awvalid_d = 1'b0;
                end
                if (m_axi_wready) begin
                    w_wvalid_d = 1'b0;
                end
                if (w_aw_done && w_w_done) begin
                    w_state_d = StResp;
                end
            end
            StResp: begin
                if (m_axi_bvalid) begin
                    w_b_hs    = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            r_state       <= StIdle;
            r_busy        <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_awaddr      <= '0;
            r_wdata       <= '0;
            r_done_cnt    <= '0;
            r_err_cnt     <= '0;
            r_drop_cnt    <= '0;
            r_len_error   <= 1'b0;
            r_align_error <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_busy    <= (w_state_d != StIdle);
            r_awvalid <= w_awvalid_d;
            r_wvalid  <= w_wvalid_d;
            if (w_accept) begin
                r_awaddr <= dram_write_addr & ~LSB_MASK;
                if ((dram_write_addr & LSB_MASK) != '0) begin
                    r_align_error <= 1'b1;
                end
                if (dram_write_len != 8'd0) begin
                    r_len_error <= 1'b1;
                end
            end
            // FIFO dout for the accepted request is valid one cycle after the strobe.
            if (r_state == StCapture) begin
                r_wdata <= dram_write_data;
            end
            if (w_drop && (r_drop_cnt != CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_b_hs) begin
                if (w_bresp_ok) begin
                    if (r_done_cnt != CNT_MAX) begin
                        r_done_cnt <= r_done_cnt + 1'b1;
                    end
                end else if (r_err_cnt != CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign dram_write_busy   = r_busy;
    assign m_axi_awaddr      = r_awaddr;
    assign m_axi_awlen       = 8'd0;
    assign m_axi_awsize      = 3'(ADDR_LSB);
    assign m_axi_awburst     = 2'b01;
    assign m_axi_awcache     = 4'b0011;
    assign m_axi_awprot      = 3'b000;
    assign m_axi_awvalid     = r_awvalid;
    assign m_axi_wdata       = r_wdata;
    assign m_axi_wstrb       = '1;
    assign m_axi_wlast       = r_wvalid;
    assign m_axi_wvalid      = r_wvalid;
    assign m_axi_bready      = (r_state == StSend) || (r_state == StResp);
    assign write_done_count  = r_done_cnt;
    assign write_error_count = r_err_cnt;
    assign drop_count        = r_drop_cnt;
    assign len_error         = r_len_error;
    assign align_error       = r_align_error;

endmodule
